// File: rtl/ysyx_23060059_lsu_sb.sv
// Load/store unit with a posted-store buffer between EXU and WBU; loads wait on same-word buffered stores.
// Latency: store/misaligned/pass-through respond 2/1/1 cycles after accept; loads add AR+R bus time.
// Backpressure: req_ready drops while a request is held; a full store buffer stalls the push until a B pops it.
module ysyx_23060059_lsu_sb #(
    parameter int BUS_W    = 64,
    parameter int SB_DEPTH = 4,
    parameter int TAG_W    = 8,
    parameter int ID_W     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_ren,
    input  logic                 req_wen,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [TAG_W-1:0]     req_tag,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic [TAG_W-1:0]     resp_tag,
    output logic                 resp_err,
    output logic                 sb_empty,
    output logic                 bus_err,
    output logic [31:0]          araddr,
    output logic                 arvalid,
    input  logic                 arready,
    output logic [ID_W-1:0]      arid,
    output logic [7:0]           arlen,
    output logic [2:0]           arsize,
    output logic [1:0]           arburst,
    input  logic [BUS_W-1:0]     rdata,
    input  logic [1:0]           rresp,
    input  logic                 rlast,
    input  logic                 rvalid,
    output logic                 rready,
    output logic [31:0]          awaddr,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [ID_W-1:0]      awid,
    output logic [7:0]           awlen,
    output logic [2:0]           awsize,
    output logic [BUS_W-1:0]     wdata,
    output logic [BUS_W/8-1:0]   wstrb,
    output logic                 wlast,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic [1:0]           bresp,
    input  logic                 bvalid,
    output logic                 bready
);
    localparam int NB  = BUS_W / 8;
    localparam int OFF = $clog2(NB);
    localparam int PW  = $clog2(SB_DEPTH);

    localparam logic [2:0] S_IDLE = 3'd0, S_PUSH = 3'd1, S_CHK = 3'd2,
                           S_AR   = 3'd3, S_R    = 3'd4, S_RESP = 3'd5;
    localparam logic [1:0] W_IDLE = 2'd0, W_SEND = 2'd1, W_B = 2'd2;

    logic [2:0]       state;
    logic [1:0]       wstate;
    logic             h_vld, h_ren, h_wen, h_sgn;
    logic [1:0]       h_size;
    logic [31:0]      h_addr, h_wdata, r_data;
    logic [TAG_W-1:0] h_tag;
    logic             r_err, aw_pend, w_pend;
    logic [PW:0]      wr_ptr, rd_ptr, sb_cnt;
    logic [31:0]      sb_addr [SB_DEPTH];
    logic [BUS_W-1:0] sb_data [SB_DEPTH];
    logic [NB-1:0]    sb_strb [SB_DEPTH];

    logic             misalign, sb_full, sb_none, push, pop, hazard;
    logic [OFF-1:0]   lane;
    logic [OFF+2:0]   lane_sh;
    logic [3:0]       size_mask;
    logic [BUS_W-1:0] st_data, rsh;
    logic [NB-1:0]    st_strb;
    logic             unused_in;

    function automatic logic [31:0] ld_ext(input logic [31:0] v, input logic [1:0] sz, input logic sg);
        case (sz)
            2'd0:    return {{24{sg & v[7]}}, v[7:0]};
            2'd1:    return {{16{sg & v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    assign misalign  = (h_size == 2'd1 && h_addr[0]) || (h_size[1] && h_addr[1:0] != 2'b00);
    assign lane      = h_addr[OFF-1:0];
    assign lane_sh   = {lane, 3'b000};
    assign size_mask = (h_size == 2'd0) ? 4'b0001 : (h_size == 2'd1) ? 4'b0011 : 4'b1111;
    assign st_data   = BUS_W'(h_wdata) << lane_sh;
    assign st_strb   = NB'(size_mask) << lane;
    assign rsh       = rdata >> lane_sh;
    assign unused_in = ^{rlast, rsh};

    assign sb_cnt  = wr_ptr - rd_ptr;
    assign sb_none = (wr_ptr == rd_ptr);
    assign sb_full = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    assign push    = (state == S_PUSH) && !sb_full;
    assign pop     = (wstate == W_B) && bvalid;

    // The head entry stays counted until its B returns, so an in-flight write still blocks a load.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (({1'b0, PW'(i) - rd_ptr[PW-1:0]} < sb_cnt) && (sb_addr[i][31:OFF] == h_addr[31:OFF]))
                hazard = 1'b1;
        end
    end

    assign req_ready  = !h_vld;
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = r_data;
    assign resp_tag   = h_tag;
    assign resp_err   = r_err;
    assign sb_empty   = sb_none && (wstate == W_IDLE);

    assign araddr  = {h_addr[31:OFF], {OFF{1'b0}}};
    assign arvalid = (state == S_AR);
    assign arid    = '0;
    assign arlen   = 8'd0;
    assign arsize  = 3'(OFF);
    assign arburst = 2'b01;
    assign rready  = (state == S_R);

    assign awaddr  = sb_addr[rd_ptr[PW-1:0]];
    assign wdata   = sb_data[rd_ptr[PW-1:0]];
    assign wstrb   = sb_strb[rd_ptr[PW-1:0]];
    assign awvalid = aw_pend;
    assign wvalid  = w_pend;
    assign awid    = '0;
    assign awlen   = 8'd0;
    assign awsize  = 3'(OFF);
    assign wlast   = 1'b1;
    assign bready  = (wstate == W_B);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            h_vld   <= 1'b0;
            h_ren   <= 1'b0;
            h_wen   <= 1'b0;
            h_sgn   <= 1'b0;
            h_size  <= 2'd0;
            h_addr  <= '0;
            h_wdata <= '0;
            h_tag   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (req_valid && !h_vld) begin
                h_vld   <= 1'b1;
                h_ren   <= req_ren;
                h_wen   <= req_wen;
                h_sgn   <= req_signed;
                h_size  <= req_size;
                h_addr  <= req_addr;
                h_wdata <= req_wdata;
                h_tag   <= req_tag;
            end
            case (state)
                S_IDLE: if (h_vld) begin
                    r_err  <= misalign;
                    r_data <= '0;
                    if (misalign)   state <= S_RESP;
                    else if (h_wen) state <= S_PUSH;
                    else if (h_ren) state <= S_CHK;
                    else            state <= S_RESP;
                end
                S_PUSH: if (!sb_full) state <= S_RESP;
                S_CHK:  if (!hazard) state <= S_AR;
                S_AR:   if (arready) state <= S_R;
                S_R: if (rvalid) begin
                    r_err  <= (rresp != 2'b00);
                    r_data <= (rresp != 2'b00) ? 32'd0 : ld_ext(rsh[31:0], h_size, h_sgn);
                    state  <= S_RESP;
                end
                S_RESP: if (resp_ready) begin
                    h_vld <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            sb_addr[wr_ptr[PW-1:0]] <= {h_addr[31:OFF], {OFF{1'b0}}};
            sb_data[wr_ptr[PW-1:0]] <= st_data;
            sb_strb[wr_ptr[PW-1:0]] <= st_strb;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            wstate  <= W_IDLE;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case (wstate)
                W_IDLE: if (!sb_none) begin
                    wstate  <= W_SEND;
                    aw_pend <= 1'b1;
                    w_pend  <= 1'b1;
                end
                W_SEND: begin
                    if (awready) aw_pend <= 1'b0;
                    if (wready)  w_pend  <= 1'b0;
                    if ((!aw_pend || awready) && (!w_pend || wready)) wstate <= W_B;
                end
                W_B: if (bvalid) begin
                    if (bresp != 2'b00) bus_err <= 1'b1;
                    wstate <= W_IDLE;
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060059_lsu_sb.sv
// Scoreboard bench for ysyx_23060059_lsu_sb: expected responses queued at accept, compared at resp handshake.
// The AXI slave is modelled at the falling edge; aw_hold stalls the write address channel.
module tb_ysyx_23060059_lsu_sb;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 0, req_ren = 0, req_wen = 0, req_signed = 0;
    logic        req_ready;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [7:0]  req_tag = 0;
    logic        resp_valid, resp_err, sb_empty, bus_err;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic [7:0]  resp_tag;
    logic [31:0] araddr, awaddr;
    logic        arvalid, rready, awvalid, wvalid, wlast, bready;
    logic        arready = 0, rvalid = 0, rlast = 0, awready = 0, wready = 0, bvalid = 0;
    logic [3:0]  arid, awid;
    logic [7:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst;
    logic [63:0] rdata = 0, wdata;
    logic [1:0]  rresp = 0, bresp = 0;

    ysyx_23060059_lsu_sb dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_ren(req_ren), .req_wen(req_wen),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_tag(req_tag), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_tag(resp_tag), .resp_err(resp_err), .sb_empty(sb_empty), .bus_err(bus_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .awid(awid), .awlen(awlen), .awsize(awsize), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // AXI slave: values set at negedge are the ones sampled on the next rising edge.
    logic        aw_hold = 1'b0;
    logic [1:0]  bresp_cfg = 0, rresp_cfg = 0;
    logic [63:0] rd_cfg = 0;
    int          aw_n = 0, w_n = 0, b_iss = 0, r_pend = 0;
    int          ar_cnt = 0, b_cnt = 0, ar_cyc = 0, b_cyc = 0;
    logic [31:0] last_awaddr = 0, last_araddr = 0;
    logic [63:0] last_wdata = 0;
    logic [7:0]  last_wstrb = 0;

    always @(negedge clock) begin
        if (reset) begin
            aw_n = 0; w_n = 0; b_iss = 0; r_pend = 0;
            arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        end else begin
            rvalid = (r_pend != 0); rdata = rd_cfg; rresp = rresp_cfg; rlast = 1'b1;
            if (rvalid && rready) r_pend = 0;
            arready = 1'b1;
            if (arvalid) begin r_pend = 1; ar_cnt++; ar_cyc = cyc; last_araddr = araddr; end
            bvalid = (((aw_n < w_n) ? aw_n : w_n) > b_iss); bresp = bresp_cfg;
            if (bvalid && bready) begin b_iss++; b_cnt++; b_cyc = cyc; end
            awready = !aw_hold; wready = 1'b1;
            if (awvalid && awready) begin aw_n++; last_awaddr = awaddr; end
            if (wvalid && wready) begin w_n++; last_wdata = wdata; last_wstrb = wstrb; end
        end
    end

    typedef struct {
        logic [7:0]  tag;
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sbq[$];
    logic [7:0] tag_ctr = 8'h10;

    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset && resp_valid && resp_ready) begin
            if (sbq.size() == 0) chk("resp_unexpected", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("resp_tag", resp_tag, e.tag);
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", resp_err, e.err);
                if (e.lat >= 0) chk("resp_latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic send(input logic ren, input logic wen, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e, input int lat);
        int n = 0;
        exp_t e;
        req_valid = 1; req_ren = ren; req_wen = wen; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; req_tag = tag_ctr;
        while (!req_ready && n < 200) begin @(negedge clock); n++; end
        if (!req_ready) begin
            chk("req_accept_timeout", 0, 1);
            req_valid = 0;
            return;
        end
        e.tag = tag_ctr; e.rdata = exp_d; e.err = exp_e; e.acc = cyc + 1; e.lat = lat;
        sbq.push_back(e);
        tag_ctr++;
        @(negedge clock);
        req_valid = 0;
    endtask

    task automatic wait_resp(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin @(negedge clock); n++; end
        if (sbq.size() != 0) begin
            chk("resp_timeout", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    task automatic wait_sb_empty(input int budget);
        int n = 0;
        while (!sb_empty && n < budget) begin @(negedge clock); n++; end
        chk("sb_drain", sb_empty, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int ar0, b0;
        repeat (3) @(negedge clock);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_sb_empty", sb_empty, 1);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        reset = 0;
        @(negedge clock);

        // sw into the upper half of a 64-bit word
        send(0, 1, 2'd2, 0, 32'h8000_0004, 32'hdead_beef, 32'h0, 0, 2);
        wait_resp(50);
        wait_sb_empty(100);
        chk("t1_awaddr", last_awaddr, 32'h8000_0000);
        chk("t1_wstrb", last_wstrb, 8'hf0);
        chk("t1_wdata_hi", last_wdata[63:32], 32'hdead_beef);

        // byte/half/word loads with sign and zero extension
        rd_cfg = 64'h0000_0000_8000_0000;
        send(1, 0, 2'd0, 1, 32'h8000_0003, 0, 32'hffff_ff80, 0, -1);
        wait_resp(50);
        chk("t2_araddr", last_araddr, 32'h8000_0000);
        send(1, 0, 2'd0, 0, 32'h8000_0003, 0, 32'h0000_0080, 0, -1);
        wait_resp(50);
        rd_cfg = 64'h8765_4321_0000_0000;
        send(1, 0, 2'd1, 1, 32'h8000_0006, 0, 32'hffff_8765, 0, -1);
        send(1, 0, 2'd1, 0, 32'h8000_0006, 0, 32'h0000_8765, 0, -1);
        send(1, 0, 2'd2, 0, 32'h8000_0004, 0, 32'h8765_4321, 0, -1);
        wait_resp(50);

        // misaligned, pass-through and read error
        ar0 = ar_cnt;
        send(1, 0, 2'd1, 1, 32'h8000_0001, 0, 32'h0, 1, 1);
        send(1, 0, 2'd2, 0, 32'h8000_0002, 0, 32'h0, 1, 1);
        send(0, 1, 2'd2, 0, 32'h8000_0006, 32'h1, 32'h0, 1, 1);
        send(0, 0, 2'd2, 0, 32'h8000_0000, 0, 32'h0, 0, 1);
        wait_resp(50);
        chk("t5_no_ar", ar_cnt, ar0);
        rresp_cfg = 2'd2;
        send(1, 0, 2'd2, 0, 32'h8000_0000, 0, 32'h0, 1, -1);
        wait_resp(50);
        rresp_cfg = 2'd0;

        // fill the buffer with awready held low; the fifth store stalls
        aw_hold = 1; b0 = b_cnt;
        for (int i = 0; i < 4; i++) send(0, 1, 2'd2, 0, 32'h8000_0100 + 32'(8 * i), 32'(i), 32'h0, 0, 2);
        wait_resp(50);
        send(0, 1, 2'd2, 0, 32'h8000_0120, 32'h5, 32'h0, 0, -1);
        repeat (10) @(negedge clock);
        chk("t3_stall_ready", req_ready, 0);
        chk("t3_stall_noresp", sbq.size(), 1);
        aw_hold = 0;
        wait_resp(200);
        wait_sb_empty(200);
        chk("t3_b_count", b_cnt - b0, 5);

        // load hazard against a buffered store
        rd_cfg = 64'h1122_3344_5566_7788;
        aw_hold = 1;
        send(0, 1, 2'd2, 0, 32'h8000_0200, 32'h9, 32'h0, 0, 2);
        wait_resp(50);
        ar0 = ar_cnt; b0 = b_cnt;
        send(1, 0, 2'd2, 0, 32'h8000_0204, 0, 32'h1122_3344, 0, -1);
        repeat (20) @(negedge clock);
        chk("t4_hazard_no_ar", ar_cnt, ar0);
        chk("t4_hazard_noresp", sbq.size(), 1);
        aw_hold = 0;
        wait_resp(200);
        chk("t4_ar_issued", ar_cnt, ar0 + 1);
        chk("t4_ar_after_b", ar_cyc > b_cyc, 1);
        wait_sb_empty(100);
        aw_hold = 1; b0 = b_cnt;
        send(0, 1, 2'd2, 0, 32'h8000_0300, 32'h7, 32'h0, 0, 2);
        send(1, 0, 2'd2, 0, 32'h8000_0400, 0, 32'h5566_7788, 0, -1);
        wait_resp(100);
        chk("t4_ar_before_b", b_cnt, b0);
        aw_hold = 0;
        wait_sb_empty(100);

        // write error is sticky
        chk("berr_before", bus_err, 0);
        bresp_cfg = 2'd2;
        send(0, 1, 2'd0, 0, 32'h8000_0013, 32'h0000_00ab, 32'h0, 0, 2);
        wait_resp(50);
        wait_sb_empty(100);
        chk("berr_wstrb", last_wstrb, 8'h08);
        chk("berr_wbyte", last_wdata[31:24], 8'hab);
        chk("berr_set", bus_err, 1);
        bresp_cfg = 2'd0;

        // asynchronous reset mid write
        aw_hold = 1;
        for (int i = 0; i < 3; i++) send(0, 1, 2'd2, 0, 32'h8000_0500 + 32'(8 * i), 32'(i), 32'h0, 0, -1);
        wait_resp(50);
        @(negedge clock);
        chk("t6_awvalid_pre", awvalid, 1);
        #2 reset = 1;
        #1;
        chk("t6_awvalid", awvalid, 0);
        chk("t6_sb_empty", sb_empty, 1);
        chk("t6_resp_valid", resp_valid, 0);
        chk("t6_bus_err", bus_err, 0);
        chk("t6_req_ready", req_ready, 1);
        repeat (2) @(negedge clock);
        reset = 0; aw_hold = 0;
        @(negedge clock);

        // recovery after reset
        send(0, 1, 2'd2, 0, 32'h8000_0008, 32'h1234_5678, 32'h0, 0, 2);
        wait_resp(50);
        wait_sb_empty(100);
        chk("rec_awaddr", last_awaddr, 32'h8000_0008);
        chk("rec_wstrb", last_wstrb, 8'h0f);
        chk("rec_wdata", last_wdata[31:0], 32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
